mem_access_unit: RTL and testbench

Memory-stage access unit that consumes the execute/memory pipeline register outputs and performs each load or store on the data-memory bus. It uses a req/gnt/rvalid handshake, aligns store data and byte strobes, and sign- or zero-extends load data. It asserts a stall toward the hazard unit until the access completes.

---
 rtl/mem_access_unit.sv | 133 +++++++++++++
 tb/tb_mem_access_unit.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// Memory-stage access unit: drives the data-memory req/gnt/rvalid bus for one
// load or store at a time, aligning store lanes and extending load data.
module mem_access_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] m_addr,
  input  logic [31:0] m_wdata,
  input  logic [3:0]  m_w_en,
  input  logic        m_load,
  input  logic [2:0]  m_func3,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [3:0]  dm_wstrb,
  output logic [31:0] dm_wdata,
  input  logic        dm_gnt,
  input  logic        dm_rvalid,
  input  logic [31:0] dm_rdata,
  output logic        mem_stall,
  output logic [31:0] ld_data,
  output logic        ld_valid,
  output logic        misalign
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t      state_q;
  logic        dmReq_q;
  logic        dmWe_q;
  logic [31:0] dmAddr_q;
  logic [3:0]  dmWstrb_q;
  logic [31:0] dmWdata_q;
  logic [31:0] ldData_q;
  logic        ldValid_q;
  logic [1:0]  offset_q;
  logic [2:0]  func3_q;
  logic        isLoad_q;

  logic        isStore;
  logic        isLoad;
  logic        opPresent;
  logic        opMisaligned;
  logic        opGo;
  logic [31:0] rdataShifted;
  logic [31:0] ldData_d;

  // A store mask takes priority over the load flag when both are set.
  always_comb begin
    isStore      = (m_w_en != 4'b0000);
    isLoad       = !isStore && m_load;
    opPresent    = isStore || isLoad;
    opMisaligned = opPresent &&
                   (((m_func3[1:0] == 2'b01) && m_addr[0]) ||
                    ((m_func3[1:0] == 2'b10) && (m_addr[1:0] != 2'b00)));
    opGo         = (state_q == IDLE) && opPresent && !opMisaligned;
    misalign     = (state_q == IDLE) && opMisaligned;
    mem_stall    = opGo || (state_q == REQ) || (state_q == WAIT);
  end

  always_comb begin
    rdataShifted = dm_rdata >> {offset_q, 3'b000};
    ldData_d     = rdataShifted;
    case (func3_q)
      3'b000:  ldData_d = {{24{rdataShifted[7]}}, rdataShifted[7:0]};
      3'b001:  ldData_d = {{16{rdataShifted[15]}}, rdataShifted[15:0]};
      3'b100:  ldData_d = {24'h000000, rdataShifted[7:0]};
      3'b101:  ldData_d = {16'h0000, rdataShifted[15:0]};
      default: ldData_d = rdataShifted;
    endcase
  end

  // Bus outputs are captured once in IDLE and held until the next op starts.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      dmReq_q   <= 1'b0;
      dmWe_q    <= 1'b0;
      dmAddr_q  <= 32'h0;
      dmWstrb_q <= 4'h0;
      dmWdata_q <= 32'h0;
      ldData_q  <= 32'h0;
      ldValid_q <= 1'b0;
      offset_q  <= 2'b00;
      func3_q   <= 3'b000;
      isLoad_q  <= 1'b0;
    end else begin
      ldValid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (opGo) begin
            state_q   <= REQ;
            dmReq_q   <= 1'b1;
            dmWe_q    <= isStore;
            dmAddr_q  <= {m_addr[31:2], 2'b00};
            dmWstrb_q <= m_w_en << m_addr[1:0];
            dmWdata_q <= m_wdata << {m_addr[1:0], 3'b000};
            offset_q  <= m_addr[1:0];
            func3_q   <= m_func3;
            isLoad_q  <= isLoad;
          end
        end
        REQ: begin
          if (dm_gnt) begin
            dmReq_q <= 1'b0;
            state_q <= isLoad_q ? WAIT : DONE;
          end
        end
        WAIT: begin
          if (dm_rvalid) begin
            ldData_q  <= ldData_d;
            ldValid_q <= 1'b1;
            state_q   <= DONE;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign dm_req   = dmReq_q;
  assign dm_we    = dmWe_q;
  assign dm_addr  = dmAddr_q;
  assign dm_wstrb = dmWstrb_q;
  assign dm_wdata = dmWdata_q;
  assign ld_data  = ldData_q;
  assign ld_valid = ldValid_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: the bench plays the data memory,
// choosing gnt/rvalid latency per op, and checks bus, stall and load results.
module tb_mem_access_unit;

  logic        clk;
  logic        rst;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [3:0]  m_w_en;
  logic        m_load;
  logic [2:0]  m_func3;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [3:0]  dm_wstrb;
  logic [31:0] dm_wdata;
  logic        dm_gnt;
  logic        dm_rvalid;
  logic [31:0] dm_rdata;
  logic        mem_stall;
  logic [31:0] ld_data;
  logic        ld_valid;
  logic        misalign;

  int checks;
  int fails;

  int          opStalls;
  int          opPulses;
  bit          opDone;
  bit          reqSeen;
  logic        capWe;
  logic [31:0] capAddr;
  logic [3:0]  capStrb;
  logic [31:0] capWdata;

  mem_access_unit dut (
    .clk       (clk),
    .rst       (rst),
    .m_addr    (m_addr),
    .m_wdata   (m_wdata),
    .m_w_en    (m_w_en),
    .m_load    (m_load),
    .m_func3   (m_func3),
    .dm_req    (dm_req),
    .dm_we     (dm_we),
    .dm_addr   (dm_addr),
    .dm_wstrb  (dm_wstrb),
    .dm_wdata  (dm_wdata),
    .dm_gnt    (dm_gnt),
    .dm_rvalid (dm_rvalid),
    .dm_rdata  (dm_rdata),
    .mem_stall (mem_stall),
    .ld_data   (ld_data),
    .ld_valid  (ld_valid),
    .misalign  (misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Plays one op from its IDLE cycle through DONE; returns in the next IDLE cycle.
  task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [3:0] wen, input logic load,
                               input logic [2:0] f3, input int gntDelay,
                               input int rvDelay, input logic [31:0] rdata);
    int  reqIdx;
    int  gntAt;
    bit  loadEff;
    m_addr = addr; m_wdata = wdata; m_w_en = wen; m_load = load; m_func3 = f3;
    dm_rdata = rdata; dm_gnt = 1'b0; dm_rvalid = 1'b0;
    loadEff = (wen == 4'b0000) && load;
    opStalls = 0; opPulses = 0; opDone = 1'b0; reqSeen = 1'b0;
    reqIdx = 0; gntAt = -1;
    for (int cyc = 0; cyc < 60 && !opDone; cyc++) begin
      #1;
      if (mem_stall) opStalls++;
      if (ld_valid) opPulses++;
      if (dm_req && !reqSeen) begin
        reqSeen = 1'b1; capWe = dm_we; capAddr = dm_addr;
        capStrb = dm_wstrb; capWdata = dm_wdata;
      end
      if (gntAt >= 0 && !mem_stall) opDone = 1'b1;
      dm_gnt = 1'b0;
      dm_rvalid = 1'b0;
      if (dm_req) begin
        if (reqIdx == gntDelay) begin dm_gnt = 1'b1; gntAt = cyc; end
        reqIdx++;
      end
      if (gntAt >= 0 && loadEff && cyc == gntAt + rvDelay) dm_rvalid = 1'b1;
      @(posedge clk); #1;
    end
    dm_gnt = 1'b0;
    dm_rvalid = 1'b0;
  endtask

  task automatic clearInputs();
    m_addr = 32'h0; m_wdata = 32'h0; m_w_en = 4'h0; m_load = 1'b0; m_func3 = 3'b000;
  endtask

  task automatic test_reset();
    #2;
    checks++; if (dm_req !== 1'b0) begin fails++; $display("[TB] FAIL reset dm_req got %b want 0", dm_req); end
    checks++; if (dm_we !== 1'b0) begin fails++; $display("[TB] FAIL reset dm_we got %b want 0", dm_we); end
    checks++; if (dm_addr !== 32'h0) begin fails++; $display("[TB] FAIL reset dm_addr got %h want 0", dm_addr); end
    checks++; if (dm_wstrb !== 4'h0) begin fails++; $display("[TB] FAIL reset dm_wstrb got %b want 0", dm_wstrb); end
    checks++; if (dm_wdata !== 32'h0) begin fails++; $display("[TB] FAIL reset dm_wdata got %h want 0", dm_wdata); end
    checks++; if (ld_data !== 32'h0) begin fails++; $display("[TB] FAIL reset ld_data got %h want 0", ld_data); end
    checks++; if (ld_valid !== 1'b0) begin fails++; $display("[TB] FAIL reset ld_valid got %b want 0", ld_valid); end
    checks++; if (mem_stall !== 1'b0) begin fails++; $display("[TB] FAIL reset mem_stall got %b want 0", mem_stall); end
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_store_word();
    applyStimulus(32'h100, 32'hDEADBEEF, 4'b1111, 1'b0, 3'b010, 0, 0, 32'h0);
    clearInputs();
    checks++; if (opDone !== 1'b1) begin fails++; $display("[TB] FAIL sw done got %b want 1", opDone); end
    checks++; if (capAddr !== 32'h100) begin fails++; $display("[TB] FAIL sw dm_addr got %h want 00000100", capAddr); end
    checks++; if (capStrb !== 4'b1111) begin fails++; $display("[TB] FAIL sw dm_wstrb got %b want 1111", capStrb); end
    checks++; if (capWe !== 1'b1) begin fails++; $display("[TB] FAIL sw dm_we got %b want 1", capWe); end
    checks++; if (capWdata !== 32'hDEADBEEF) begin fails++; $display("[TB] FAIL sw dm_wdata got %h want deadbeef", capWdata); end
    checks++; if (opStalls != 2) begin fails++; $display("[TB] FAIL sw stalls got %0d want 2", opStalls); end
    checks++; if (opPulses != 0) begin fails++; $display("[TB] FAIL sw ld_valid pulses got %0d want 0", opPulses); end
  endtask

  task automatic test_store_byte();
    applyStimulus(32'h103, 32'h000000A5, 4'b0001, 1'b0, 3'b000, 0, 0, 32'h0);
    clearInputs();
    checks++; if (capStrb !== 4'b1000) begin fails++; $display("[TB] FAIL sb dm_wstrb got %b want 1000", capStrb); end
    checks++; if (capWdata !== 32'hA5000000) begin fails++; $display("[TB] FAIL sb dm_wdata got %h want a5000000", capWdata); end
    checks++; if (capAddr !== 32'h100) begin fails++; $display("[TB] FAIL sb dm_addr got %h want 00000100", capAddr); end
    applyStimulus(32'h0FE, 32'h0000BEEF, 4'b0011, 1'b0, 3'b001, 1, 0, 32'h0);
    clearInputs();
    checks++; if (capStrb !== 4'b1100) begin fails++; $display("[TB] FAIL sh dm_wstrb got %b want 1100", capStrb); end
    checks++; if (capWdata !== 32'hBEEF0000) begin fails++; $display("[TB] FAIL sh dm_wdata got %h want beef0000", capWdata); end
    checks++; if (opStalls != 3) begin fails++; $display("[TB] FAIL sh stalls got %0d want 3", opStalls); end
  endtask

  task automatic test_loads();
    logic [2:0]  f3Tab   [4] = '{3'b000, 3'b100, 3'b001, 3'b101};
    logic [31:0] rdTab   [4] = '{32'h1280FF34, 32'h1280FF34, 32'h80010000, 32'h80010000};
    logic [31:0] expTab  [4] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF8001, 32'h00008001};
    int          rvTab   [4] = '{3, 3, 1, 1};
    int          stTab   [4] = '{5, 5, 3, 3};
    for (int i = 0; i < 4; i++) begin
      applyStimulus(32'h202, 32'h0, 4'b0000, 1'b1, f3Tab[i], 0, rvTab[i], rdTab[i]);
      clearInputs();
      checks++; if (ld_data !== expTab[i]) begin fails++; $display("[TB] FAIL load%0d ld_data got %h want %h", i, ld_data, expTab[i]); end
      checks++; if (opPulses != 1) begin fails++; $display("[TB] FAIL load%0d ld_valid pulses got %0d want 1", i, opPulses); end
      checks++; if (opStalls != stTab[i]) begin fails++; $display("[TB] FAIL load%0d stalls got %0d want %0d", i, opStalls, stTab[i]); end
      checks++; if (capWe !== 1'b0 || capAddr !== 32'h200) begin fails++; $display("[TB] FAIL load%0d bus we/addr got %b/%h want 0/00000200", i, capWe, capAddr); end
    end
    #1;
    checks++; if (ld_valid !== 1'b0) begin fails++; $display("[TB] FAIL load ld_valid after done got %b want 0", ld_valid); end
  endtask

  task automatic test_misalign();
    logic [31:0] aTab [3] = '{32'h201, 32'h102, 32'h101};
    logic [3:0]  wTab [3] = '{4'b0000, 4'b0000, 4'b0011};
    logic [2:0]  fTab [3] = '{3'b001, 3'b010, 3'b001};
    for (int i = 0; i < 3; i++) begin
      m_addr = aTab[i]; m_wdata = 32'h12345678; m_w_en = wTab[i];
      m_load = (wTab[i] == 4'b0000); m_func3 = fTab[i];
      for (int c = 0; c < 3; c++) begin
        #1;
        checks++; if (misalign !== 1'b1) begin fails++; $display("[TB] FAIL misalign%0d flag got %b want 1", i, misalign); end
        checks++; if (mem_stall !== 1'b0 || dm_req !== 1'b0) begin fails++; $display("[TB] FAIL misalign%0d stall/req got %b/%b want 0/0", i, mem_stall, dm_req); end
        @(posedge clk); #1;
      end
      checks++; if (ld_data !== 32'h00008001) begin fails++; $display("[TB] FAIL misalign%0d ld_data got %h want 00008001", i, ld_data); end
    end
    clearInputs();
    #1;
    checks++; if (misalign !== 1'b0) begin fails++; $display("[TB] FAIL misalign idle flag got %b want 0", misalign); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    applyStimulus(32'h040, 32'h11223344, 4'b1111, 1'b1, 3'b010, 2, 1, 32'h0);
    checks++; if (opStalls != 4) begin fails++; $display("[TB] FAIL b2b store stalls got %0d want 4", opStalls); end
    checks++; if (opPulses != 0) begin fails++; $display("[TB] FAIL b2b store ld_valid pulses got %0d want 0", opPulses); end
    checks++; if (capWe !== 1'b1) begin fails++; $display("[TB] FAIL b2b store dm_we got %b want 1", capWe); end
    checks++; if (ld_data !== 32'h00008001) begin fails++; $display("[TB] FAIL b2b store ld_data got %h want 00008001", ld_data); end
    applyStimulus(32'h040, 32'h0, 4'b0000, 1'b1, 3'b010, 0, 1, 32'h55667788);
    clearInputs();
    checks++; if (opStalls != 3) begin fails++; $display("[TB] FAIL b2b load stalls got %0d want 3", opStalls); end
    checks++; if (opPulses != 1) begin fails++; $display("[TB] FAIL b2b load ld_valid pulses got %0d want 1", opPulses); end
    checks++; if (ld_data !== 32'h55667788) begin fails++; $display("[TB] FAIL b2b load ld_data got %h want 55667788", ld_data); end
  endtask

  task automatic test_reset_midop();
    m_addr = 32'h300; m_w_en = 4'b0000; m_load = 1'b1; m_func3 = 3'b010;
    @(posedge clk); #1;
    checks++; if (dm_req !== 1'b1) begin fails++; $display("[TB] FAIL rst-req dm_req before got %b want 1", dm_req); end
    #2; rst = 1'b0; #1;
    checks++; if (dm_req !== 1'b0) begin fails++; $display("[TB] FAIL rst-req dm_req got %b want 0", dm_req); end
    clearInputs();
    @(negedge clk); rst = 1'b1;
    applyStimulus(32'h204, 32'h0, 4'b0000, 1'b1, 3'b010, 0, 1, 32'h0BADF00D);
    checks++; if (ld_data !== 32'h0BADF00D) begin fails++; $display("[TB] FAIL rst-wait setup ld_data got %h want 0badf00d", ld_data); end
    m_addr = 32'h300; m_load = 1'b1; m_func3 = 3'b010;
    @(posedge clk); #1;
    dm_gnt = 1'b1;
    @(posedge clk); #1;
    dm_gnt = 1'b0;
    checks++; if (mem_stall !== 1'b1) begin fails++; $display("[TB] FAIL rst-wait in-wait stall got %b want 1", mem_stall); end
    #2; rst = 1'b0; clearInputs(); #1;
    checks++; if (dm_req !== 1'b0 || ld_valid !== 1'b0) begin fails++; $display("[TB] FAIL rst-wait req/valid got %b/%b want 0/0", dm_req, ld_valid); end
    checks++; if (mem_stall !== 1'b0) begin fails++; $display("[TB] FAIL rst-wait idle stall got %b want 0", mem_stall); end
    checks++; if (ld_data !== 32'h0) begin fails++; $display("[TB] FAIL rst-wait ld_data got %h want 0", ld_data); end
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    applyStimulus(32'h010, 32'h0, 4'b0000, 1'b1, 3'b010, 1, 1, 32'hCAFEF00D);
    clearInputs();
    checks++; if (ld_data !== 32'hCAFEF00D) begin fails++; $display("[TB] FAIL post-rst lw ld_data got %h want cafef00d", ld_data); end
    checks++; if (opStalls != 4 || opPulses != 1) begin fails++; $display("[TB] FAIL post-rst lw stalls/pulses got %0d/%0d want 4/1", opStalls, opPulses); end
    checks++; if (capAddr !== 32'h10) begin fails++; $display("[TB] FAIL post-rst lw dm_addr got %h want 00000010", capAddr); end
  endtask

  initial begin
    checks = 0; fails = 0;
    rst = 1'b0; dm_gnt = 1'b0; dm_rvalid = 1'b0; dm_rdata = 32'h0;
    clearInputs();
    test_reset();
    test_store_word();
    test_store_byte();
    test_loads();
    test_misalign();
    test_back_to_back();
    test_reset_midop();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
